mix_pipe_unit: RTL and testbench

MIX_PIPE_UNIT -- requirements
Module: mix_pipe_unit

---
 rtl/mix_pipe_unit.sv | 205 ++++++++++++++++++++
 tb/tb_mix_pipe_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_pipe_unit.sv
// mix_pipe_unit: HALF/BYTE/ROT mixing unit with an NR_STAGES-deep in-order pipeline.
// Define MIX_PIPE_UNIT_ITER_EN to add the multi-cycle ITER operation (op 3) and its FSM.

package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

package riscv;
  localparam int unsigned XLEN = 32;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

package ariane_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    riscv::xlen_t             operand_a;
    riscv::xlen_t             operand_b;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    riscv::xlen_t cause;
    riscv::xlen_t tval;
    logic         valid;
  } exception_t;
endpackage

module mix_pipe_unit #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NR_STAGES = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                mix_valid_i,
  input  logic [1:0]                          mix_op_i,
  input  ariane_pkg::fu_data_t                fu_data_i,
  output logic                                mix_ready_o,
  output riscv::xlen_t                        mix_result_o,
  output logic                                mix_valid_o,
  output logic [ariane_pkg::TRANS_ID_BITS-1:0] mix_trans_id_o,
  output ariane_pkg::exception_t              mix_exception_o
);

  localparam int unsigned XLEN    = riscv::XLEN;
  localparam int unsigned HALF_W  = XLEN / 2;
  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned ID_W    = ariane_pkg::TRANS_ID_BITS;

  localparam logic [1:0] OP_BYTE = 2'd1;
  localparam logic [1:0] OP_ROT  = 2'd2;

  if (NR_STAGES < 1 || NR_STAGES > 4) begin : g_bad_stages
    $error("mix_pipe_unit: NR_STAGES must be within 1..4");
  end

  if (CVA6Cfg.XLEN != 0 && CVA6Cfg.XLEN != XLEN) begin : g_bad_xlen
    $error("mix_pipe_unit: CVA6Cfg.XLEN disagrees with riscv::XLEN");
  end

  riscv::xlen_t op_a;
  riscv::xlen_t op_b;
  riscv::xlen_t comb_result;
  logic         accept;
  logic         pipe_accept;
  logic         pipe_out_valid;

  assign op_a            = fu_data_i.operand_a;
  assign op_b            = fu_data_i.operand_b;
  assign accept          = mix_valid_i & mix_ready_o & ~flush_i;
  assign mix_exception_o = '0;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    comb_result = '0;
    case (mix_op_i)
      OP_BYTE: begin
        for (int j = 0; j < int'(XLEN / 16); j++) begin
          comb_result[16*j +: 8]   = op_a[8*j +: 8];
          comb_result[16*j+8 +: 8] = op_b[8*j +: 8];
        end
      end
      OP_ROT:  comb_result = riscv::xlen_t'({op_a, op_a} >> op_b[SHAMT_W-1:0]);
      default: comb_result = {op_b[HALF_W-1:0], op_a[XLEN-1:HALF_W]};
    endcase
  end

  logic [NR_STAGES-1:0]           stage_valid;
  logic [NR_STAGES-1:0][ID_W-1:0] stage_id;
  logic [NR_STAGES-1:0][XLEN-1:0] stage_data;

  // NOTE: state registers use non-blocking <= so each stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid <= '0;
      stage_id    <= '0;
    end else begin
      stage_valid[0] <= pipe_accept;
      stage_id[0]    <= fu_data_i.trans_id;
      for (int s = 1; s < int'(NR_STAGES); s++) begin
        stage_valid[s] <= stage_valid[s-1] & ~flush_i;
        stage_id[s]    <= stage_id[s-1];
      end
    end
  end

  // NOTE: payload registers have no reset; stage_valid qualifies every use of them.
  always_ff @(posedge clk_i) begin
    stage_data[0] <= comb_result;
    for (int s = 1; s < int'(NR_STAGES); s++) begin
      stage_data[s] <= stage_data[s-1];
    end
  end

  assign pipe_out_valid = stage_valid[NR_STAGES-1];

`ifdef MIX_PIPE_UNIT_ITER_EN
  localparam logic [1:0] OP_ITER = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state;
  riscv::xlen_t    iter_r;
  riscv::xlen_t    iter_b;
  logic [3:0]      iter_cnt;
  logic [ID_W-1:0] iter_id;
  logic            iter_accept;
  logic            iter_out_valid;

  assign mix_ready_o    = (state == ST_IDLE);
  assign iter_accept    = accept && (mix_op_i == OP_ITER);
  assign pipe_accept    = accept && (mix_op_i != OP_ITER);
  // The pipeline owns the output port; a finished ITER waits in DONE until it is free.
  assign iter_out_valid = (state == ST_DONE) && !pipe_out_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      iter_r   <= '0;
      iter_b   <= '0;
      iter_cnt <= '0;
      iter_id  <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iter_accept) begin
            iter_r   <= op_a;
            iter_b   <= op_b;
            iter_cnt <= {1'b0, op_b[2:0]} + 4'd1;
            iter_id  <= fu_data_i.trans_id;
            state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          iter_r   <= {iter_r[7:0], iter_r[XLEN-1:8]} ^ iter_b;
          iter_cnt <= iter_cnt - 4'd1;
          if (iter_cnt == 4'd1) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!pipe_out_valid) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mix_valid_o = pipe_out_valid | iter_out_valid;

  always_comb begin
    mix_result_o   = '0;
    mix_trans_id_o = '0;
    if (pipe_out_valid) begin
      mix_result_o   = stage_data[NR_STAGES-1];
      mix_trans_id_o = stage_id[NR_STAGES-1];
    end else if (iter_out_valid) begin
      mix_result_o   = iter_r;
      mix_trans_id_o = iter_id;
    end
  end
`else
  // Without ITER the upper half of operand_b feeds nothing.
  logic unused_op_b_hi;
  assign unused_op_b_hi = ^op_b[XLEN-1:HALF_W];

  assign mix_ready_o    = 1'b1;
  assign pipe_accept    = accept;
  assign mix_valid_o    = pipe_out_valid;
  assign mix_result_o   = pipe_out_valid ? stage_data[NR_STAGES-1] : '0;
  assign mix_trans_id_o = pipe_out_valid ? stage_id[NR_STAGES-1] : '0;
`endif

endmodule

// File: tb/tb_mix_pipe_unit.sv
// Self-checking bench for mix_pipe_unit (XLEN=32, NR_STAGES=2); a queue scoreboard checks
// every output's value, trans_id and exact cycle. ITER scenarios run when MIX_PIPE_UNIT_ITER_EN is defined.

module tb_mix_pipe_unit;
  localparam int unsigned NR_STAGES = 2;

  typedef struct {
    int unsigned due;
    logic [31:0] res;
    logic [2:0]  id;
  } exp_t;

  logic                   clk         = 1'b0;
  logic                   rst_ni      = 1'b0;
  logic                   flush_i     = 1'b0;
  logic                   mix_valid_i = 1'b0;
  logic [1:0]             mix_op_i    = 2'd0;
  ariane_pkg::fu_data_t   fu_data_i   = '0;
  logic                   mix_ready_o;
  logic                   mix_valid_o;
  riscv::xlen_t           mix_result_o;
  logic [2:0]             mix_trans_id_o;
  ariane_pkg::exception_t mix_exception_o;

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  mix_pipe_unit #(
    .CVA6Cfg  (config_pkg::cva6_cfg_empty),
    .NR_STAGES(NR_STAGES)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .mix_valid_i    (mix_valid_i),
    .mix_op_i       (mix_op_i),
    .fu_data_i      (fu_data_i),
    .mix_ready_o    (mix_ready_o),
    .mix_result_o   (mix_result_o),
    .mix_valid_o    (mix_valid_o),
    .mix_trans_id_o (mix_trans_id_o),
    .mix_exception_o(mix_exception_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required the run to finish earlier");
    $fatal(1);
  end

  // Scoreboard monitor: outputs are sampled on the falling edge; flush/reset cycles are unspecified.
  always @(negedge clk) begin
    if (rst_ni && !flush_i) begin
      if (mix_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got result %h id %0d at cycle %0d, required no output",
                   mix_result_o, mix_trans_id_o, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mix_result_o !== mon_e.res || mix_trans_id_o !== mon_e.id || cyc != mon_e.due) begin
            errors++;
            $display("FAIL result: got %h id %0d cycle %0d, required %h id %0d cycle %0d",
                     mix_result_o, mix_trans_id_o, cyc, mon_e.res, mon_e.id, mon_e.due);
          end
        end
      end else begin
        checks++;
        if (mix_result_o !== 32'h0 || mix_trans_id_o !== 3'd0) begin
          errors++;
          $display("FAIL idle_outputs: got result %h id %0d with valid low, required 0 and 0",
                   mix_result_o, mix_trans_id_o);
        end
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          mon_e = exp_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_output: got no valid at cycle %0d, required %h id %0d",
                   cyc, mon_e.res, mon_e.id);
        end
      end
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  s;
    case (op)
      2'd1: r = {b[15:8], a[15:8], b[7:0], a[7:0]};
      2'd2: begin
        s = b[4:0];
        r = (a >> s) | (a << (6'd32 - {1'b0, s}));
      end
      default: r = (a >> 16) | (b << 16);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] iter_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r = a;
    for (int k = 0; k <= int'(b[2:0]); k++) r = ((r >> 8) | (r << 24)) ^ b;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request for one cycle and records what should come out lat cycles later.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] id, input logic [31:0] exp_res, input int unsigned lat);
    exp_t e;
    mix_valid_i         = 1'b1;
    mix_op_i            = op;
    fu_data_i.operand_a = a;
    fu_data_i.operand_b = b;
    fu_data_i.trans_id  = id;
    e.due = cyc + lat;
    e.res = exp_res;
    e.id  = id;
    exp_q.push_back(e);
    tick(1);
    mix_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic quiet_window(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mix_valid_o !== 1'b0 || mix_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL %s_quiet: got valid %b ready %b, required valid 0 ready 1",
                 name, mix_valid_o, mix_ready_o);
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_ni              = 1'b0;
    mix_valid_i         = 1'b1;
    fu_data_i.operand_a = 32'hDEAD_BEEF;
    fu_data_i.operand_b = 32'h1234_5678;
    fu_data_i.trans_id  = 3'd5;
    tick(3);
    checks++;
    if (mix_valid_o !== 1'b0 || mix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got valid %b ready %b, required valid 0 ready 1", mix_valid_o, mix_ready_o);
    end
    checks++;
    if (mix_result_o !== 32'h0 || mix_trans_id_o !== 3'd0 || mix_exception_o !== '0) begin
      errors++;
      $display("FAIL reset_data: got result %h id %0d, required 0 and 0", mix_result_o, mix_trans_id_o);
    end
    mix_valid_i = 1'b0;
    #3 rst_ni = 1'b1;
    tick(1);
    quiet_window("post_reset", 3);
  endtask

  task automatic test_half();
    issue(2'd0, 32'hA4A3_A2A1, 32'hB4B3_B2B1, 3'd3, 32'hB2B1_A4A3, NR_STAGES);
    checks++;
    if (mix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL half_latency: got valid %b one cycle after issue, required 0", mix_valid_o);
    end
    tick(1);
    checks++;
    if (mix_valid_o !== 1'b1 || mix_result_o !== 32'hB2B1_A4A3 || mix_trans_id_o !== 3'd3) begin
      errors++;
      $display("FAIL half_direct: got valid %b result %h id %0d, required 1 b2b1a4a3 3",
               mix_valid_o, mix_result_o, mix_trans_id_o);
    end
    wait_drain("half");
  endtask

  task automatic test_byte_rot();
    issue(2'd1, 32'h4433_2211, 32'h8877_6655, 3'd1, 32'h6622_5511, NR_STAGES);
    issue(2'd2, 32'h0000_0001, 32'h0000_0004, 3'd2, 32'h1000_0000, NR_STAGES);
    issue(2'd2, 32'h8000_0001, 32'h0000_0000, 3'd4, 32'h8000_0001, NR_STAGES);
    issue(2'd2, 32'h8000_0001, 32'hFFFF_FFFF, 3'd6, 32'h0000_0003, NR_STAGES);
    issue(2'd1, 32'hFFFF_0000, 32'h0000_FFFF, 3'd7, 32'hFF00_FF00, NR_STAGES);
    wait_drain("byte_rot");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom();
      b = $urandom();
      issue(2'd0, a, b, 3'(i), model(2'd0, a, b), NR_STAGES);
      checks++;
      if (mix_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready: got ready %b during HALF burst, required 1", mix_ready_o);
      end
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_random_mix();
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 16; i++) begin
`ifdef MIX_PIPE_UNIT_ITER_EN
      op = 2'($urandom_range(0, 2));
`else
      op = 2'($urandom_range(0, 3));
`endif
      a = $urandom();
      b = $urandom();
      issue(op, a, b, 3'(i), model(op, a, b), NR_STAGES);
    end
    wait_drain("random_mix");
  endtask

  task automatic test_flush_pipe();
    issue(2'd0, 32'h0102_0304, 32'h0506_0708, 3'd1, 32'h0708_0102, NR_STAGES);
    issue(2'd0, 32'h1111_2222, 32'h3333_4444, 3'd2, 32'h4444_1111, NR_STAGES);
    exp_q.delete();
    flush_i             = 1'b1;
    mix_valid_i         = 1'b1;
    mix_op_i            = 2'd0;
    fu_data_i.operand_a = 32'hAAAA_5555;
    fu_data_i.trans_id  = 3'd3;
    tick(1);
    flush_i     = 1'b0;
    mix_valid_i = 1'b0;
    quiet_window("flush_pipe", 5);
    issue(2'd1, 32'h4433_2211, 32'h8877_6655, 3'd4, 32'h6622_5511, NR_STAGES);
    wait_drain("after_flush");
  endtask

  task automatic test_reset_mid_pipe();
    issue(2'd0, 32'hCAFE_0001, 32'hBEEF_0002, 3'd1, 32'h0002_CAFE, NR_STAGES);
    issue(2'd2, 32'h0000_00F0, 32'h0000_0004, 3'd2, 32'h0000_000F, NR_STAGES);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (mix_valid_o !== 1'b0 || mix_ready_o !== 1'b1 || mix_result_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got valid %b ready %b result %h, required 0 1 0",
               mix_valid_o, mix_ready_o, mix_result_o);
    end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    tick(1);
    quiet_window("reset_mid_pipe", 5);
  endtask

`ifdef MIX_PIPE_UNIT_ITER_EN
  task automatic test_iter();
    issue(2'd3, 32'h1234_5678, 32'h0000_0001, 3'd5, 32'h5778_1235, 3);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mix_ready_o !== 1'b0 || mix_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL iter_busy: got ready %b valid %b, required 0 0", mix_ready_o, mix_valid_o);
      end
      tick(1);
    end
    checks++;
    if (mix_ready_o !== 1'b0 || mix_valid_o !== 1'b1 || mix_result_o !== 32'h5778_1235 || mix_trans_id_o !== 3'd5) begin
      errors++;
      $display("FAIL iter_done: got ready %b valid %b result %h id %0d, required 0 1 57781235 5",
               mix_ready_o, mix_valid_o, mix_result_o, mix_trans_id_o);
    end
    tick(1);
    checks++;
    if (mix_ready_o !== 1'b1 || mix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL iter_idle: got ready %b valid %b, required 1 0", mix_ready_o, mix_valid_o);
    end
    issue(2'd3, 32'hA5A5_0F0F, 32'h0000_0006, 3'd2, iter_model(32'hA5A5_0F0F, 32'h0000_0006), 8);
    wait_drain("iter");
  endtask

  task automatic test_iter_after_half();
    issue(2'd0, 32'h1111_2222, 32'h3333_4444, 3'd1, 32'h4444_1111, NR_STAGES);
    checks++;
    if (mix_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL iter_after_half_ready: got ready %b, required 1", mix_ready_o);
    end
    issue(2'd3, 32'hCAFE_F00D, 32'h0000_0000, 3'd6, 32'h0DCA_FEF0, 2);
    checks++;
    if (mix_valid_o !== 1'b1 || mix_trans_id_o !== 3'd1) begin
      errors++;
      $display("FAIL iter_after_half_first: got valid %b id %0d, required 1 1", mix_valid_o, mix_trans_id_o);
    end
    tick(1);
    checks++;
    if (mix_valid_o !== 1'b1 || mix_trans_id_o !== 3'd6) begin
      errors++;
      $display("FAIL iter_after_half_second: got valid %b id %0d, required 1 6", mix_valid_o, mix_trans_id_o);
    end
    wait_drain("iter_after_half");
  endtask

  task automatic test_flush_busy();
    issue(2'd3, 32'h0F0F_0F0F, 32'h0000_0007, 3'd3, iter_model(32'h0F0F_0F0F, 32'h0000_0007), 9);
    tick(2);
    exp_q.delete();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    quiet_window("flush_busy", 12);
  endtask

  task automatic test_reset_mid_iter();
    issue(2'd3, 32'h8765_4321, 32'h0000_0005, 3'd4, iter_model(32'h8765_4321, 32'h0000_0005), 7);
    tick(2);
    rst_ni = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (mix_ready_o !== 1'b1 || mix_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_iter: got ready %b valid %b, required 1 0", mix_ready_o, mix_valid_o);
    end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    tick(1);
    quiet_window("reset_mid_iter", 10);
  endtask
`else
  task automatic test_op3_as_half();
    issue(2'd3, 32'h1111_2222, 32'h3333_4444, 3'd5, 32'h4444_1111, NR_STAGES);
    issue(2'd3, 32'hA4A3_A2A1, 32'hB4B3_B2B1, 3'd6, 32'hB2B1_A4A3, NR_STAGES);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mix_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL op3_ready: got ready %b, required 1", mix_ready_o);
      end
      tick(1);
    end
    wait_drain("op3");
  endtask
`endif

  initial begin
    test_reset();
    test_half();
    test_byte_rot();
    test_back_to_back();
`ifdef MIX_PIPE_UNIT_ITER_EN
    test_iter();
    test_iter_after_half();
`else
    test_op3_as_half();
`endif
    test_random_mix();
    test_flush_pipe();
`ifdef MIX_PIPE_UNIT_ITER_EN
    test_flush_busy();
    test_reset_mid_iter();
`endif
    test_reset_mid_pipe();
    test_half();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
